// File: rtl/cpu_clk_ctrl_if.sv
// Control and status bundle between the board-level switches and buttons, the CPU's
// halt request and the CPU clock-enable controller.
interface cpu_clk_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       mode_sel;
  logic             step_btn;
  logic             resume_btn;
  logic             halt_req;
  logic             cpu_ce;
  logic             cpu_ce_led;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_count;

  // Board side drives the switches, buttons and halt request; the controller drives
  // the enable pulse and its status.
  modport master (
    output mode_sel, step_btn, resume_btn, halt_req,
    input  cpu_ce, cpu_ce_led, state, cycle_count
  );

  modport slave (
    input  mode_sel, step_btn, resume_btn, halt_req,
    output cpu_ce, cpu_ce_led, state, cycle_count
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Run/step/hold/halt controller producing a single-cycle CPU clock enable on the board
// clock, with synchronised switches and debounced step/resume buttons.
module cpu_clk_ctrl #(
  parameter int FAST_DIV   = 8,
  parameter int SLOW_DIV   = 33554432,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  cpu_clk_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STEP   = 2'b01,
    ST_HOLD   = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(FAST_DIV - 1);
  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(SLOW_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_M1  = DEB_W'(DEB_CYCLES - 1);

  // Button vectors: bit 0 = step, bit 1 = resume.
  logic [1:0]            mode_s1_q, mode_s2_q;
  logic [1:0]            btn_s1_q, btn_s2_q;
  logic [1:0]            btn_deb_q, btn_deb_d;
  logic [1:0]            press_q, press_d;
  logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  state_e           state_q, state_d;
  logic             eff_slow_q, eff_slow_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             ce_q, ce_d;
  logic             led_q, led_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             halt_prev_q, halt_prev_d;

  state_e mode_state;
  logic   mode_slow;
  logic   mode_change;
  logic   period_last;
  logic   halt_edge;

  // The debounced level only moves after the synced level has disagreed with it for
  // DEB_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    btn_deb_d = btn_deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (btn_s2_q[i] == btn_deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_M1) begin
        btn_deb_d[i] = btn_s2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
      end
    end
    press_d = btn_deb_d & ~btn_deb_q;
  end

  always_comb begin
    mode_state  = mode_s2_q[1] ? (mode_s2_q[0] ? ST_HOLD : ST_STEP) : ST_RUN;
    mode_slow   = (mode_s2_q == 2'b01);
    mode_change = (mode_state != state_q) || (mode_slow != eff_slow_q);
    period_last = (state_q == ST_RUN) && (div_cnt_q == (eff_slow_q ? SLOW_M1 : FAST_M1));
    halt_edge   = bus.halt_req & ~halt_prev_q;
  end

  always_comb begin
    state_d     = state_q;
    eff_slow_d  = eff_slow_q;
    div_cnt_d   = div_cnt_q;
    ce_d        = 1'b0;
    halt_prev_d = bus.halt_req;
    if (halt_edge) begin
      // A pulse already due at this period end still goes out.
      state_d   = ST_HALTED;
      div_cnt_d = '0;
      ce_d      = period_last;
    end else begin
      case (state_q)
        ST_HALTED: begin
          if (press_q[1]) begin
            state_d    = mode_state;
            eff_slow_d = mode_slow;
            div_cnt_d  = '0;
          end
        end
        ST_RUN: begin
          ce_d = period_last;
          if (period_last) begin
            div_cnt_d  = '0;
            state_d    = mode_state;
            eff_slow_d = mode_slow;
          end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // STEP and HOLD treat every cycle as a boundary; a mode change beats a step.
          div_cnt_d = '0;
          if (mode_change) begin
            state_d    = mode_state;
            eff_slow_d = mode_slow;
          end else if (state_q == ST_STEP) begin
            ce_d = press_q[0];
          end
        end
      endcase
    end
    led_d         = led_q ^ ce_d;
    cycle_count_d = cycle_count_q + CNT_W'(ce_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_s1_q     <= '0;
      mode_s2_q     <= '0;
      btn_s1_q      <= '0;
      btn_s2_q      <= '0;
      btn_deb_q     <= '0;
      press_q       <= '0;
      deb_cnt_q     <= '0;
      state_q       <= ST_RUN;
      eff_slow_q    <= 1'b0;
      div_cnt_q     <= '0;
      ce_q          <= 1'b0;
      led_q         <= 1'b0;
      cycle_count_q <= '0;
      halt_prev_q   <= 1'b0;
    end else begin
      mode_s1_q     <= bus.mode_sel;
      mode_s2_q     <= mode_s1_q;
      btn_s1_q      <= {bus.resume_btn, bus.step_btn};
      btn_s2_q      <= btn_s1_q;
      btn_deb_q     <= btn_deb_d;
      press_q       <= press_d;
      deb_cnt_q     <= deb_cnt_d;
      state_q       <= state_d;
      eff_slow_q    <= eff_slow_d;
      div_cnt_q     <= div_cnt_d;
      ce_q          <= ce_d;
      led_q         <= led_d;
      cycle_count_q <= cycle_count_d;
      halt_prev_q   <= halt_prev_d;
    end
  end

  assign bus.cpu_ce      = ce_q;
  assign bus.cpu_ce_led  = led_q;
  assign bus.state       = state_q;
  assign bus.cycle_count = cycle_count_q;

endmodule
